// File: rtl/crc_tx_if.sv
// crc_tx_if: handshake bundle between the packet serialiser and crc_tx_gen.
// CRC_TX_PAR_OUT_EN adds the parallel remainder/match signals used for receive checking.
`ifdef CRC_TX_PAR_OUT_EN
interface crc_tx_if #(parameter int CRC_W = 16);
    logic halt_tx, start, data_valid, data_in, append;
    logic data_ready, tx_bit, tx_valid, crc_done;
    logic [CRC_W-1:0] crc_value;
    logic crc_match;
    modport master(output halt_tx, start, data_valid, data_in, append,
                   input data_ready, tx_bit, tx_valid, crc_done, crc_value, crc_match);
    modport slave(input halt_tx, start, data_valid, data_in, append,
                  output data_ready, tx_bit, tx_valid, crc_done, crc_value, crc_match);
endinterface
`else
interface crc_tx_if;
    logic halt_tx, start, data_valid, data_in, append;
    logic data_ready, tx_bit, tx_valid, crc_done;
    modport master(output halt_tx, start, data_valid, data_in, append,
                   input data_ready, tx_bit, tx_valid, crc_done);
    modport slave(input halt_tx, start, data_valid, data_in, append,
                  output data_ready, tx_bit, tx_valid, crc_done);
endinterface
`endif

// File: rtl/crc_tx_gen.sv
// crc_tx_gen: serial CRC accumulator that appends its (optionally complemented) remainder MSB first.
// CRC_TX_PAR_OUT_EN adds crc_value/crc_match outputs so the block can double as a receive checker.
module crc_tx_gen #(
    parameter int CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h8005),
    parameter logic [CRC_W-1:0] INIT = '1,
    parameter bit XOR_OUT = 1'b1
) (
    input logic clk_c,
    input logic reset_z,
    crc_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;
    state_t state, state_n;
    logic [CRC_W-1:0] crc, crc_n;
    logic [5:0] cnt, cnt_n;
    logic tx_bit, tx_bit_n, tx_valid, tx_valid_n, last, last_n, done, fb;
    assign fb = bus.data_in ^ crc[CRC_W-1];
    always_ff @(posedge clk_c or negedge reset_z)
        if (!reset_z) begin
            state <= IDLE;
            crc <= INIT;
            cnt <= '0;
            tx_bit <= 1'b0;
            tx_valid <= 1'b0;
            last <= 1'b0;
            done <= 1'b0;
        end else if (!bus.halt_tx) begin
            state <= state_n;
            crc <= crc_n;
            cnt <= cnt_n;
            tx_bit <= tx_bit_n;
            tx_valid <= tx_valid_n;
            last <= last_n;
            done <= last;
        end
    // start wins over everything in IDLE/DATA; a payload bit arriving with it is dropped
    always_comb begin
        state_n = state;
        crc_n = crc;
        cnt_n = cnt;
        tx_bit_n = tx_bit;
        tx_valid_n = 1'b0;
        last_n = 1'b0;
        case (state)
            IDLE, DATA:
                if (bus.start) begin
                    crc_n = INIT;
                    cnt_n = '0;
                    state_n = bus.append ? APPEND : DATA;
                end else if (state == DATA) begin
                    if (bus.data_valid) begin
                        crc_n = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                        tx_bit_n = bus.data_in;
                        tx_valid_n = 1'b1;
                    end
                    if (bus.append) begin
                        cnt_n = '0;
                        state_n = APPEND;
                    end
                end
            default: begin
                tx_bit_n = crc[CRC_W-1] ^ XOR_OUT;
                tx_valid_n = 1'b1;
                crc_n = {crc[CRC_W-2:0], 1'b0};
                cnt_n = cnt + 6'd1;
                if (cnt == 6'(CRC_W - 1)) begin
                    state_n = IDLE;
                    last_n = 1'b1;
                end
            end
        endcase
    end
    assign bus.data_ready = state != APPEND;
    assign bus.tx_bit = tx_bit;
    assign bus.tx_valid = tx_valid;
    assign bus.crc_done = done & ~bus.halt_tx;
`ifdef CRC_TX_PAR_OUT_EN
    localparam logic [CRC_W-1:0] RESID = (CRC_W == 5) ? CRC_W'(5'h0C) : CRC_W'(16'h800D);
    assign bus.crc_value = crc ^ {CRC_W{XOR_OUT}};
    assign bus.crc_match = crc == RESID;
`endif
endmodule

// File: tb/tb_crc_tx_gen.sv
// tb_crc_tx_gen: scoreboard bench driving a CRC5 and a CRC16 crc_tx_gen side by side.
module tb_crc_tx_gen;
    logic clk_c = 1'b0, reset_z = 1'b0;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int last_v5 = -1, last_v16 = -1, done5 = -1, done16 = -1;
    logic cap5[$], cap16[$], exp5[$], exp16[$];
`ifdef CRC_TX_PAR_OUT_EN
    crc_tx_if #(.CRC_W(5)) i5();
    crc_tx_if #(.CRC_W(16)) i16();
`else
    crc_tx_if i5();
    crc_tx_if i16();
`endif
    crc_tx_gen #(.CRC_W(5), .POLY(5'h05)) u5(.clk_c(clk_c), .reset_z(reset_z), .bus(i5.slave));
    crc_tx_gen u16(.clk_c(clk_c), .reset_z(reset_z), .bus(i16.slave));

    always #5 clk_c = ~clk_c;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_calc(int w, logic [31:0] poly, logic [31:0] d, int n);
        logic [31:0] c, m;
        m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        c = m;
        for (int i = n - 1; i >= 0; i--)
            c = ((c << 1) & m) ^ ((d[i] ^ c[w-1]) ? poly : 32'd0);
        return c;
    endfunction

    // one clock; records every fresh valid bit (frozen outputs during halt are not new bits)
    task automatic tick();
        logic h5, h16;
        h5 = i5.halt_tx;
        h16 = i16.halt_tx;
        @(posedge clk_c);
        #1;
        cyc++;
        if (i5.tx_valid && !h5) begin cap5.push_back(i5.tx_bit); last_v5 = cyc; end
        if (i16.tx_valid && !h16) begin cap16.push_back(i16.tx_bit); last_v16 = cyc; end
        if (i5.crc_done) done5 = cyc;
        if (i16.crc_done) done16 = cyc;
    endtask

    task automatic clear_inputs();
        {i5.halt_tx, i5.start, i5.data_valid, i5.data_in, i5.append} = '0;
        {i16.halt_tx, i16.start, i16.data_valid, i16.data_in, i16.append} = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_z = 1'b0;
        repeat (2) @(posedge clk_c);
        #1;
        n_cmp++;
        if ({i5.data_ready, i5.tx_valid, i5.tx_bit, i5.crc_done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset5 got %b want 1000", {i5.data_ready, i5.tx_valid, i5.tx_bit, i5.crc_done});
        end
        n_cmp++;
        if ({i16.data_ready, i16.tx_valid, i16.tx_bit, i16.crc_done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset16 got %b want 1000", {i16.data_ready, i16.tx_valid, i16.tx_bit, i16.crc_done});
        end
`ifdef CRC_TX_PAR_OUT_EN
        n_cmp++;
        if (i16.crc_value !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_crc_value got %h want 0000", i16.crc_value);
        end
`endif
        @(negedge clk_c);
        reset_z = 1'b1;
        i16.data_valid = 1'b1;
        i16.data_in = 1'b1;
        tick();
        clear_inputs();
        n_cmp++;
        if (i16.tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignores_data got %b want 0", i16.tx_valid);
        end
    endtask

    task automatic test_crc5_zero();
        logic [4:0] crc_bits = 5'b01000;
        logic e, g;
        cap5.delete(); exp5.delete(); done5 = -1;
        i5.start = 1'b1; tick(); i5.start = 1'b0;
        i5.data_valid = 1'b1; i5.data_in = 1'b0;
        repeat (11) begin exp5.push_back(1'b0); tick(); end
        i5.data_valid = 1'b0; i5.append = 1'b1; tick(); i5.append = 1'b0;
        for (int k = 4; k >= 0; k--) exp5.push_back(crc_bits[k]);
        for (int k = 0; k < 40 && done5 < 0; k++) tick();
        n_cmp++;
        if (done5 < 0) begin n_bad++; $display("FAIL crc5_done got timeout want pulse"); end
        while (exp5.size() > 0) begin
            e = exp5.pop_front();
            g = (cap5.size() > 0) ? cap5.pop_front() : 1'bx;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL crc5_bit got %b want %b", g, e); end
        end
        n_cmp++;
        if (cap5.size() != 0) begin n_bad++; $display("FAIL crc5_extra got %0d want 0", cap5.size()); end
        n_cmp++;
        if (done5 != last_v5 + 1) begin n_bad++; $display("FAIL crc5_done_cycle got %0d want %0d", done5, last_v5 + 1); end
    endtask

    task automatic test_zero_len();
        int n = 0;
        logic e, g;
        cap16.delete(); exp16.delete(); done16 = -1;
        i16.start = 1'b1; i16.append = 1'b1; tick(); i16.start = 1'b0; i16.append = 1'b0;
        repeat (16) exp16.push_back(1'b0);
        while (!i16.data_ready && n < 40) begin n++; tick(); end
        n_cmp++;
        if (n != 16) begin n_bad++; $display("FAIL zero_len_ready_low got %0d want 16", n); end
        for (int k = 0; k < 40 && done16 < 0; k++) tick();
        n_cmp++;
        if (done16 < 0) begin n_bad++; $display("FAIL zero_len_done got timeout want pulse"); end
        while (exp16.size() > 0) begin
            e = exp16.pop_front();
            g = (cap16.size() > 0) ? cap16.pop_front() : 1'bx;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL zero_len_bit got %b want %b", g, e); end
        end
        n_cmp++;
        if (cap16.size() != 0) begin n_bad++; $display("FAIL zero_len_extra got %0d want 0", cap16.size()); end
    endtask

    task automatic test_halt();
        logic [7:0] p = 8'hA5;
        logic [15:0] c;
        logic e, g;
        int span[2];
        c = 16'(~crc_calc(16, 32'h8005, 32'(p), 8));
        for (int pass = 0; pass < 2; pass++) begin
            cap16.delete(); exp16.delete(); done16 = -1;
            i16.start = 1'b1; tick(); i16.start = 1'b0;
            span[pass] = cyc;
            for (int k = 7; k >= 0; k--) begin
                if (pass == 1 && k == 3) begin
                    i16.halt_tx = 1'b1; i16.data_valid = 1'b1; i16.data_in = ~p[k];
                    repeat (3) tick();
                    i16.halt_tx = 1'b0;
                end
                i16.data_valid = 1'b1; i16.data_in = p[k]; exp16.push_back(p[k]); tick();
            end
            i16.data_valid = 1'b0; i16.append = 1'b1; tick(); i16.append = 1'b0;
            for (int k = 15; k >= 0; k--) exp16.push_back(c[k]);
            if (pass == 1) begin
                repeat (6) tick();
                i16.halt_tx = 1'b1; repeat (3) tick(); i16.halt_tx = 1'b0;
            end
            for (int k = 0; k < 60 && done16 < 0; k++) tick();
            n_cmp++;
            if (done16 < 0) begin n_bad++; $display("FAIL halt_done pass%0d got timeout want pulse", pass); end
            span[pass] = done16 - span[pass];
            while (exp16.size() > 0) begin
                e = exp16.pop_front();
                g = (cap16.size() > 0) ? cap16.pop_front() : 1'bx;
                n_cmp++;
                if (g !== e) begin n_bad++; $display("FAIL halt_bit pass%0d got %b want %b", pass, g, e); end
            end
            n_cmp++;
            if (cap16.size() != 0) begin n_bad++; $display("FAIL halt_extra pass%0d got %0d want 0", pass, cap16.size()); end
        end
        n_cmp++;
        if (span[1] != span[0] + 6) begin n_bad++; $display("FAIL halt_stretch got %0d want %0d", span[1], span[0] + 6); end
    endtask

    task automatic test_restart();
        logic [4:0] crc_bits = 5'b01000;
        logic e, g;
        cap5.delete(); exp5.delete(); done5 = -1;
        i5.start = 1'b1; tick(); i5.start = 1'b0;
        i5.data_valid = 1'b1; i5.data_in = 1'b1;
        repeat (4) begin exp5.push_back(1'b1); tick(); end
        i5.start = 1'b1; tick(); i5.start = 1'b0;
        i5.data_in = 1'b0;
        repeat (11) begin exp5.push_back(1'b0); tick(); end
        i5.data_valid = 1'b0; i5.append = 1'b1; tick(); i5.append = 1'b0;
        for (int k = 4; k >= 0; k--) exp5.push_back(crc_bits[k]);
        for (int k = 0; k < 40 && done5 < 0; k++) tick();
        n_cmp++;
        if (done5 < 0) begin n_bad++; $display("FAIL restart_done got timeout want pulse"); end
        while (exp5.size() > 0) begin
            e = exp5.pop_front();
            g = (cap5.size() > 0) ? cap5.pop_front() : 1'bx;
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL restart_bit got %b want %b", g, e); end
        end
        n_cmp++;
        if (cap5.size() != 0) begin n_bad++; $display("FAIL restart_extra got %0d want 0", cap5.size()); end
    endtask

    task automatic test_reset_mid();
        int n = 0, cs;
        cap16.delete(); done16 = -1;
        i16.start = 1'b1; tick(); i16.start = 1'b0;
        i16.data_valid = 1'b1; i16.data_in = 1'b1; repeat (8) tick(); i16.data_valid = 1'b0;
        i16.append = 1'b1; tick(); i16.append = 1'b0;
        while (cap16.size() < 15 && n < 40) begin tick(); n++; end
        n_cmp++;
        if (i16.tx_valid !== 1'b1 || i16.data_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_crc_bit7 got %b%b want 10", i16.tx_valid, i16.data_ready);
        end
        #2 reset_z = 1'b0;
        #1;
        n_cmp++;
        if ({i16.tx_valid, i16.data_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL async_abort got %b want 01", {i16.tx_valid, i16.data_ready});
        end
        @(negedge clk_c);
        reset_z = 1'b1;
        cs = cap16.size();
        done16 = -1;
        repeat (20) tick();
        n_cmp++;
        if (cap16.size() != cs || done16 >= 0 || i16.data_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_abort got bits=%0d done=%0d ready=%b want bits=0 done=-1 ready=1",
                     cap16.size() - cs, done16, i16.data_ready);
        end
`ifdef CRC_TX_PAR_OUT_EN
        n_cmp++;
        if (i16.crc_value !== 16'h0000) begin
            n_bad++;
            $display("FAIL post_abort_crc got %h want 0000", i16.crc_value);
        end
`endif
    endtask

`ifdef CRC_TX_PAR_OUT_EN
    task automatic test_par();
        logic [7:0] p = 8'h3C;
        logic [15:0] c;
        c = 16'(~crc_calc(16, 32'h8005, 32'(p), 8));
        i16.start = 1'b1; tick(); i16.start = 1'b0;
        n_cmp++;
        if (i16.crc_value !== 16'h0000) begin n_bad++; $display("FAIL par_init got %h want 0000", i16.crc_value); end
        i16.data_valid = 1'b1;
        for (int k = 7; k >= 0; k--) begin i16.data_in = p[k]; tick(); end
        for (int k = 15; k >= 0; k--) begin i16.data_in = c[k]; tick(); end
        i16.data_valid = 1'b0;
        n_cmp++;
        if (i16.crc_match !== 1'b1 || i16.crc_value !== 16'h7FF2) begin
            n_bad++;
            $display("FAIL par_match got %b/%h want 1/7ff2", i16.crc_match, i16.crc_value);
        end
        i16.start = 1'b1; tick(); i16.start = 1'b0;
        n_cmp++;
        if (i16.crc_match !== 1'b0) begin n_bad++; $display("FAIL par_nomatch got %b want 0", i16.crc_match); end
    endtask
`endif

    initial begin
        test_reset();
        test_crc5_zero();
        test_zero_len();
        test_halt();
        test_restart();
        test_reset_mid();
`ifdef CRC_TX_PAR_OUT_EN
        test_par();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
